ans_enc_sched: RTL and testbench
================================

ANS_ENC_SCHED -- requirements
Module: ans_enc_sched

Interface
REQ-001 Parameter NSYM, default 16: number of symbols in the frequency table.
REQ-002 Parameters SYM_WIDTH, CNT_WIDTH and STATE_WIDTH SHALL take the shared `SYM_WIDTH/`CNT_WIDTH/`STATE_WIDTH values; SIDX_WIDTH = clog2(NSYM).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ena  in  1  clock enable; when low all state SHALL hold.
REQ-006 cfg_we  in  1  write cfg_count into table entry cfg_sym.
REQ-007 cfg_sym  in  SIDX_WIDTH  table index for write.
REQ-008 cfg_count  in  CNT_WIDTH  symbol frequency.
REQ-009 cfg_commit  in  1  start cumulative/total computation.
REQ-010 cfg_rdy  out  1  config writes/commit accepted this cycle.
REQ-011 sym_in  in  SIDX_WIDTH  symbol to encode; sym_vld in 1; sym_last in 1 (end of stream); sym_rdy out 1.
REQ-012 enc_count  out  CNT_WIDTH; enc_cumulative  out  SYM_WIDTH+CNT_WIDTH; enc_total  out  STATE_WIDTH: encoder operands.
REQ-013 enc_vld  out  1; enc_rdy  in  1: valid/ready to encoder input.
REQ-014 table_ok out 1 (table committed, legal); err_zero out 1 (sticky, zero-count symbol seen); err_total out 1 (sticky, bad total); done out 1 (one-cycle pulse).

Function
REQ-015 States SHALL be IDLE, PREFIX, READY, ISSUE, ERR.
REQ-016 cfg_rdy SHALL be 1 only in IDLE, READY (no symbol held) and ERR; cfg_we/cfg_commit SHALL be ignored when cfg_rdy is 0.
REQ-017 Any accepted cfg_we SHALL clear table_ok and move to IDLE.
REQ-018 Accepted cfg_commit SHALL enter PREFIX, which walks index 0..NSYM-1, one entry per cycle, storing cum[i] = sum of count[0..i-1] and accumulating the total; PREFIX SHALL last exactly NSYM cycles.
REQ-019 The accumulator SHALL be STATE_WIDTH+1 bits; after PREFIX, total == 0 or total >= 2^STATE_WIDTH SHALL go to ERR, set err_total and keep table_ok 0; otherwise go to READY with table_ok 1 and enc_total = total.
REQ-020 sym_rdy SHALL be 1 only in READY; a symbol is accepted on sym_vld && sym_rdy && ena.
REQ-021 On acceptance of a symbol with count 0, it SHALL be dropped, err_zero set, and the state SHALL remain READY (done still pulses if sym_last).
REQ-022 Otherwise the symbol SHALL be registered and the state SHALL enter ISSUE; enc_vld SHALL rise the next cycle (1-cycle latency) with enc_count = count[sym] and enc_cumulative = cum[sym].
REQ-023 enc_vld and the operands SHALL stay stable until enc_vld && enc_rdy; on that cycle enc_vld SHALL drop, and the state SHALL return to READY, with sym_rdy high the following cycle.
REQ-024 The sym_last captured with a symbol SHALL cause done to pulse in the cycle after the encoder handshake.
REQ-025 In ERR, sym_rdy and enc_vld SHALL be 0; only a new cfg_we/cfg_commit leaves ERR.
REQ-026 err_zero and err_total SHALL clear only on reset or on an accepted cfg_commit.

Reset
REQ-027 On rst: state IDLE, table counts and cum all 0, enc_total 0, table_ok 0, err_* 0, done 0, enc_vld 0, sym_rdy 0, cfg_rdy 1, enc_count/enc_cumulative 0.
REQ-028 Reset mid-PREFIX or mid-ISSUE SHALL abandon the operation with no enc_vld or done afterward.

Structure
REQ-029 The shared package SHALL hold the state enum, the width defines and the NSYM default.
REQ-030 Table storage (count and cum arrays, one write port, one read port) SHALL be a sub-module ans_freq_table; the FSM and prefix accumulator SHALL remain in ans_enc_sched.

Verification
REQ-031 Counts {3,5,0,8, rest 0}, commit -> after exactly 16 cycles table_ok=1, enc_total=16, cum[3]=8.
REQ-032 Send symbol 1 with enc_rdy held 0 for 5 cycles -> enc_vld=1, enc_count=5, enc_cumulative=3 stable for all 5 cycles; sym_rdy=0 throughout.
REQ-033 Send symbol 2 (count 0) with sym_last=1 -> no enc_vld, err_zero=1, done pulses, sym_rdy stays 1.
REQ-034 NSYM=16, CNT_WIDTH=4, STATE_WIDTH=8: all counts 15 (total 240) -> READY; all counts 0 -> ERR with err_total=1.
REQ-035 cfg_we pulsed while ISSUE is active -> ignored; table unchanged, transaction completes normally.
REQ-036 rst asserted in the 4th PREFIX cycle -> all outputs at reset values the next cycle, table_ok=0.

Source files
------------

// File: rtl/ans_enc_sched_pkg.sv
// Shared widths, defaults and FSM state encoding for the ANS encoder scheduler.
package ans_enc_sched_pkg;

    localparam int unsigned NSYM_DEF        = 16;
    localparam int unsigned SYM_WIDTH_DEF   = 4;
    localparam int unsigned CNT_WIDTH_DEF   = 4;
    localparam int unsigned STATE_WIDTH_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StPrefix = 3'd1;
    localparam state_t StReady  = 3'd2;
    localparam state_t StIssue  = 3'd3;
    localparam state_t StErr    = 3'd4;

endpackage

// File: rtl/ans_enc_sched_freq_table.sv
// Frequency table: per-symbol count and cumulative arrays, one write port each,
// one shared combinational read port.
module ans_freq_table #(
    parameter int unsigned NSYM       = 16,
    parameter int unsigned SIDX_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned CUM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_we,
    input  logic [SIDX_WIDTH-1:0] cnt_waddr,
    input  logic [CNT_WIDTH-1:0]  cnt_wdata,
    input  logic                  cum_we,
    input  logic [SIDX_WIDTH-1:0] cum_waddr,
    input  logic [CUM_WIDTH-1:0]  cum_wdata,
    input  logic [SIDX_WIDTH-1:0] raddr,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CUM_WIDTH-1:0]  rd_cum
);

    logic [CNT_WIDTH-1:0] cnt_q [NSYM];
    logic [CUM_WIDTH-1:0] cum_q [NSYM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NSYM); i++) begin
                cnt_q[i] <= '0;
                cum_q[i] <= '0;
            end
        end else begin
            if (cnt_we) cnt_q[cnt_waddr] <= cnt_wdata;
            if (cum_we) cum_q[cum_waddr] <= cum_wdata;
        end
    end

    assign rd_count = cnt_q[raddr];
    assign rd_cum   = cum_q[raddr];

endmodule

// File: rtl/ans_enc_sched.sv
// ANS encoder scheduler: builds cumulative frequencies from a count table, then
// issues (count, cumulative, total) operands per symbol over valid/ready.
module ans_enc_sched
    import ans_enc_sched_pkg::*;
#(
    parameter int unsigned NSYM        = NSYM_DEF,
    parameter int unsigned SYM_WIDTH   = SYM_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned STATE_WIDTH = STATE_WIDTH_DEF,
    parameter int unsigned SIDX_WIDTH  = $clog2(NSYM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           cfg_we,
    input  logic [SIDX_WIDTH-1:0]          cfg_sym,
    input  logic [CNT_WIDTH-1:0]           cfg_count,
    input  logic                           cfg_commit,
    output logic                           cfg_rdy,
    input  logic [SIDX_WIDTH-1:0]          sym_in,
    input  logic                           sym_vld,
    input  logic                           sym_last,
    output logic                           sym_rdy,
    output logic [CNT_WIDTH-1:0]           enc_count,
    output logic [SYM_WIDTH+CNT_WIDTH-1:0] enc_cumulative,
    output logic [STATE_WIDTH-1:0]         enc_total,
    output logic                           enc_vld,
    input  logic                           enc_rdy,
    output logic                           table_ok,
    output logic                           err_zero,
    output logic                           err_total,
    output logic                           done
);

    localparam int unsigned CUM_WIDTH = SYM_WIDTH + CNT_WIDTH;
    localparam int unsigned ACC_WIDTH = STATE_WIDTH + 1;

    state_t                 state_q;
    logic [SIDX_WIDTH-1:0]  idx_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   last_q, table_ok_q, err_zero_q, err_total_q, done_q;
    logic [CNT_WIDTH-1:0]   enc_count_q;
    logic [CUM_WIDTH-1:0]   enc_cum_q;
    logic [STATE_WIDTH-1:0] enc_total_q;

    logic                   in_prefix, prefix_last, total_bad;
    logic [SIDX_WIDTH-1:0]  raddr;
    logic [CNT_WIDTH-1:0]   rd_count;
    logic [CUM_WIDTH-1:0]   rd_cum;
    logic [ACC_WIDTH-1:0]   acc_next;

    always_comb begin
        cfg_rdy     = (state_q == StIdle) || (state_q == StReady) || (state_q == StErr);
        sym_rdy     = (state_q == StReady);
        enc_vld     = (state_q == StIssue);
        in_prefix   = (state_q == StPrefix);
        raddr       = in_prefix ? idx_q : sym_in;
        acc_next    = acc_q + ACC_WIDTH'(rd_count);
        prefix_last = (idx_q == SIDX_WIDTH'(NSYM - 1));
        // The extra accumulator bit flags totals that overflow the coder state.
        total_bad   = (acc_next == '0) || acc_next[STATE_WIDTH];
    end

    ans_freq_table #(
        .NSYM       (NSYM),
        .SIDX_WIDTH (SIDX_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .CUM_WIDTH  (CUM_WIDTH)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .cnt_we    (ena && cfg_rdy && cfg_we),
        .cnt_waddr (cfg_sym),
        .cnt_wdata (cfg_count),
        .cum_we    (ena && in_prefix),
        .cum_waddr (idx_q),
        .cum_wdata (CUM_WIDTH'(acc_q)),
        .raddr     (raddr),
        .rd_count  (rd_count),
        .rd_cum    (rd_cum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            last_q      <= 1'b0;
            table_ok_q  <= 1'b0;
            err_zero_q  <= 1'b0;
            err_total_q <= 1'b0;
            done_q      <= 1'b0;
            enc_count_q <= '0;
            enc_cum_q   <= '0;
            enc_total_q <= '0;
        end else if (ena) begin
            done_q <= 1'b0;
            case (state_q)
                StPrefix: begin
                    idx_q <= idx_q + 1'b1;
                    acc_q <= acc_next;
                    if (prefix_last) begin
                        if (total_bad) begin
                            state_q     <= StErr;
                            err_total_q <= 1'b1;
                        end else begin
                            state_q     <= StReady;
                            table_ok_q  <= 1'b1;
                            enc_total_q <= acc_next[STATE_WIDTH-1:0];
                        end
                    end
                end
                StReady: begin
                    if (sym_vld) begin
                        if (rd_count == '0) begin
                            err_zero_q <= 1'b1;
                            done_q     <= sym_last;
                        end else begin
                            state_q     <= StIssue;
                            enc_count_q <= rd_count;
                            enc_cum_q   <= rd_cum;
                            last_q      <= sym_last;
                        end
                    end
                end
                StIssue: begin
                    if (enc_rdy) begin
                        state_q <= StReady;
                        done_q  <= last_q;
                    end
                end
                default: ;
            endcase
            // Configuration overrides any symbol activity in the same cycle.
            if (cfg_rdy && cfg_we) begin
                table_ok_q <= 1'b0;
                state_q    <= StIdle;
            end
            if (cfg_rdy && cfg_commit) begin
                state_q     <= StPrefix;
                idx_q       <= '0;
                acc_q       <= '0;
                table_ok_q  <= 1'b0;
                err_zero_q  <= 1'b0;
                err_total_q <= 1'b0;
                enc_total_q <= '0;
            end
        end
    end

    assign enc_count      = enc_count_q;
    assign enc_cumulative = enc_cum_q;
    assign enc_total      = enc_total_q;
    assign table_ok       = table_ok_q;
    assign err_zero       = err_zero_q;
    assign err_total      = err_total_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ans_enc_sched.sv
// Directed bench for ans_enc_sched with hand-computed expectations.
module tb_ans_enc_sched;

    logic       clk = 1'b0;
    logic       rst, ena, cfg_we, cfg_commit, cfg_rdy;
    logic [3:0] cfg_sym, cfg_count, sym_in;
    logic       sym_vld, sym_last, sym_rdy, enc_vld, enc_rdy;
    logic [3:0] enc_count;
    logic [7:0] enc_cumulative, enc_total;
    logic       table_ok, err_zero, err_total, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ans_enc_sched #(
        .NSYM        (16),
        .SYM_WIDTH   (4),
        .CNT_WIDTH   (4),
        .STATE_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .cfg_we         (cfg_we),
        .cfg_sym        (cfg_sym),
        .cfg_count      (cfg_count),
        .cfg_commit     (cfg_commit),
        .cfg_rdy        (cfg_rdy),
        .sym_in         (sym_in),
        .sym_vld        (sym_vld),
        .sym_last       (sym_last),
        .sym_rdy        (sym_rdy),
        .enc_count      (enc_count),
        .enc_cumulative (enc_cumulative),
        .enc_total      (enc_total),
        .enc_vld        (enc_vld),
        .enc_rdy        (enc_rdy),
        .table_ok       (table_ok),
        .err_zero       (err_zero),
        .err_total      (err_total),
        .done           (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] s, input logic [3:0] c);
        cfg_we = 1'b1; cfg_sym = s; cfg_count = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit_and_wait();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 16; i++) tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_sym = '0; cfg_count = '0;
        sym_in = '0; sym_vld = 1'b0; sym_last = 1'b0; enc_rdy = 1'b0;
        tick(); tick();
        check("rst_cfg_rdy", 32'(cfg_rdy), 1);
        check("rst_sym_rdy", 32'(sym_rdy), 0);
        check("rst_enc_vld", 32'(enc_vld), 0);
        check("rst_table_ok", 32'(table_ok), 0);
        check("rst_enc_total", 32'(enc_total), 0);
        check("rst_enc_count", 32'(enc_count), 0);
        check("rst_errs", 32'({err_zero, err_total, done}), 0);
        rst = 1'b0;

        // Table {3,5,0,8,0...}: cum = {0,3,8,8,...}, total 16.
        cfg_write(0, 3); cfg_write(1, 5); cfg_write(2, 0); cfg_write(3, 8);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("prefix_cfg_rdy", 32'(cfg_rdy), 0);
        for (int i = 0; i < 15; i++) tick();
        check("prefix_15_not_ok", 32'(table_ok), 0);
        tick();
        check("prefix_16_ok", 32'(table_ok), 1);
        check("prefix_total", 32'(enc_total), 16);
        check("ready_sym_rdy", 32'(sym_rdy), 1);

        // Symbol 1 with encoder stalled for 5 cycles.
        sym_in = 1; sym_vld = 1'b1; sym_last = 1'b0;
        tick();
        sym_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_vld", 32'(enc_vld), 1);
            check("stall_count", 32'(enc_count), 5);
            check("stall_cum", 32'(enc_cumulative), 3);
            check("stall_sym_rdy", 32'(sym_rdy), 0);
            tick();
        end
        enc_rdy = 1'b1;
        check("hs_vld", 32'(enc_vld), 1);
        tick();
        enc_rdy = 1'b0;
        check("post_hs_vld", 32'(enc_vld), 0);
        check("post_hs_sym_rdy", 32'(sym_rdy), 1);
        check("post_hs_no_done", 32'(done), 0);

        // Symbol 3 (cum[3]=8) with sym_last: done follows the handshake.
        sym_in = 3; sym_vld = 1'b1; sym_last = 1'b1; enc_rdy = 1'b1;
        tick();
        sym_vld = 1'b0; sym_last = 1'b0;
        check("s3_vld", 32'(enc_vld), 1);
        check("s3_count", 32'(enc_count), 8);
        check("s3_cum", 32'(enc_cumulative), 8);
        check("s3_done_early", 32'(done), 0);
        tick();
        enc_rdy = 1'b0;
        check("s3_done", 32'(done), 1);
        check("s3_vld_drop", 32'(enc_vld), 0);
        tick();
        check("s3_done_pulse", 32'(done), 0);

        // Zero-count symbol with sym_last is dropped.
        sym_in = 2; sym_vld = 1'b1; sym_last = 1'b1;
        tick();
        sym_vld = 1'b0; sym_last = 1'b0;
        check("zero_no_vld", 32'(enc_vld), 0);
        check("zero_err", 32'(err_zero), 1);
        check("zero_done", 32'(done), 1);
        check("zero_sym_rdy", 32'(sym_rdy), 1);
        tick();
        check("zero_done_pulse", 32'(done), 0);
        check("zero_err_sticky", 32'(err_zero), 1);

        // Clock enable low: symbol not accepted.
        ena = 1'b0; sym_in = 1; sym_vld = 1'b1;
        tick();
        check("ena_hold_vld", 32'(enc_vld), 0);
        check("ena_hold_rdy", 32'(sym_rdy), 1);
        ena = 1'b1; sym_vld = 1'b0;

        // cfg_we during ISSUE is ignored.
        sym_in = 0; sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0;
        cfg_we = 1'b1; cfg_sym = 0; cfg_count = 9;
        check("issue_cfg_rdy", 32'(cfg_rdy), 0);
        tick();
        cfg_we = 1'b0;
        check("issue_vld", 32'(enc_vld), 1);
        check("issue_count", 32'(enc_count), 3);
        check("issue_table_ok", 32'(table_ok), 1);
        enc_rdy = 1'b1;
        tick();
        check("issue_done_rdy", 32'(sym_rdy), 1);
        sym_in = 0; sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0;
        check("table_unchanged", 32'(enc_count), 3);
        tick();
        enc_rdy = 1'b0;

        // All counts 15: total 240 fits in 8 bits.
        cfg_write(0, 15);
        check("we_clears_ok", 32'(table_ok), 0);
        for (int i = 1; i < 16; i++) cfg_write(4'(i), 15);
        commit_and_wait();
        check("full_ok", 32'(table_ok), 1);
        check("full_total", 32'(enc_total), 240);
        check("full_err_total", 32'(err_total), 0);
        check("commit_clears_err_zero", 32'(err_zero), 0);
        sym_in = 15; sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0;
        check("full_cum15", 32'(enc_cumulative), 225);
        enc_rdy = 1'b1;
        tick();
        enc_rdy = 1'b0;

        // All counts 0: total 0 -> error state.
        for (int i = 0; i < 16; i++) cfg_write(4'(i), 0);
        commit_and_wait();
        check("zero_tot_err", 32'(err_total), 1);
        check("zero_tot_ok", 32'(table_ok), 0);
        check("err_sym_rdy", 32'(sym_rdy), 0);
        check("err_cfg_rdy", 32'(cfg_rdy), 1);
        sym_vld = 1'b1; enc_rdy = 1'b1;
        tick();
        sym_vld = 1'b0; enc_rdy = 1'b0;
        check("err_no_vld", 32'(enc_vld), 0);

        // Reset in the 4th PREFIX cycle.
        cfg_write(1, 5);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick(); tick(); tick();
        check("mid_prefix", 32'(cfg_rdy), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_cfg_rdy", 32'(cfg_rdy), 1);
        check("rst_mid_ok", 32'(table_ok), 0);
        check("rst_mid_err", 32'({err_zero, err_total, done, enc_vld, sym_rdy}), 0);
        check("rst_mid_total", 32'(enc_total), 0);
        check("rst_mid_ops", 32'({enc_count, enc_cumulative}), 0);
        enc_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (enc_vld !== 1'b0 || done !== 1'b0 || sym_rdy !== 1'b0) begin
                check("rst_mid_quiet", 32'({enc_vld, done, sym_rdy}), 0);
                break;
            end
        end
        enc_rdy = 1'b0;
        // Table was cleared by reset: a commit now must see total 0.
        commit_and_wait();
        check("rst_cleared_table", 32'(err_total), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
